// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a valid/ready byte input.
// The serial line and the ready flag are both registered, so neither has a combinational path from the inputs.
//
// state | meaning
// IDLE  | line high; ready to accept a byte
// START | start bit (line low) for one bit period
// DATA  | eight data bits, LSB first, one bit period each
// STOP  | stop bit (line high) for one bit period
module uart_transmitter #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic       SOut
);

  localparam int T  = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = (T > 1) ? $clog2(T) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(T - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          bit_done;

  assign bit_done = (baud_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      SOut        <= 1'b1;
      DataInReady <= 1'b0;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          SOut     <= 1'b1;
          if (DataInValid && DataInReady) begin
            shift_reg   <= DataIn;
            SOut        <= 1'b0;
            DataInReady <= 1'b0;
            state       <= START;
          end else begin
            DataInReady <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt  <= '0;
            SOut      <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              SOut  <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              SOut      <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          // Ready rises on the edge that ends the stop bit, so the next accept is one cycle later.
          if (bit_done) begin
            baud_cnt    <= '0;
            DataInReady <= 1'b1;
            state       <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          SOut        <= 1'b1;
          DataInReady <= 1'b0;
          baud_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: accepted bytes are queued, and a line monitor
// decodes each frame sample by sample against the expected 8N1 waveform.
module tb_uart_transmitter;

  localparam int CF = 1000;
  localparam int BR = 100;
  localparam int T  = CF / BR;

  logic       clk;
  logic       rst_n;
  logic [7:0] DataIn;
  logic       DataInValid;
  logic       DataInReady;
  logic       SOut;

  uart_transmitter #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .DataIn(DataIn),
    .DataInValid(DataInValid),
    .DataInReady(DataInReady),
    .SOut(SOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Scoreboard: bytes the DUT has accepted, in order.
  logic [7:0] exp_q[$];
  int         acc_cnt = 0;
  bit         rst_seen = 1'b0;

  always @(posedge clk) begin
    rst_seen <= rst_n;
    if (rst_n && DataInValid && DataInReady) begin
      exp_q.push_back(DataIn);
      acc_cnt <= acc_cnt + 1;
    end
  end

  // Line monitor
  int         cyc = 0;
  bit         active = 1'b0;
  bit         skip = 1'b0;
  bit         post_chk = 1'b0;
  bit         rst_seen_d = 1'b0;
  int         pos = 0;
  int         bad = 0;
  logic [7:0] cur = 8'h00;
  int         starts[$];

  always @(negedge clk) begin
    logic exp_bit;
    int   bidx;
    cyc++;
    if (!rst_seen) begin
      check("reset_line_sout", int'(SOut), 1);
      check("reset_ready", int'(DataInReady), 0);
      active   = 1'b0;
      post_chk = 1'b0;
    end else begin
      if (!rst_seen_d) begin
        check("ready_after_reset", int'(DataInReady), 1);
      end else if (post_chk) begin
        check("ready_after_stop", int'(DataInReady), 1);
        check("sout_after_stop", int'(SOut), 1);
        post_chk = 1'b0;
      end
      if (!active && SOut === 1'b0) begin
        starts.push_back(cyc);
        active = 1'b1;
        pos    = 0;
        bad    = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          skip = 1'b1;
        end else begin
          cur  = exp_q.pop_front();
          skip = 1'b0;
        end
      end
      if (active) begin
        bidx = pos / T;
        if (bidx == 0) exp_bit = 1'b0;
        else if (bidx == 9) exp_bit = 1'b1;
        else exp_bit = cur[bidx-1];
        if (SOut !== exp_bit || DataInReady !== 1'b0) bad++;
        if (pos % T == T - 1) begin
          if (!skip) check($sformatf("frame_%02h_bit%0d_bad_samples", cur, bidx), bad, 0);
          bad = 0;
        end
        pos++;
        if (pos == 10 * T) begin
          active   = 1'b0;
          post_chk = 1'b1;
        end
      end
    end
    rst_seen_d = rst_seen;
  end

  // Stimulus (always driven from the falling edge)
  task automatic wait_accept();
    int a0 = acc_cnt;
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (acc_cnt == a0 && n < 3000);
    if (acc_cnt == a0) check("accept_timeout", 1, 0);
  endtask

  task automatic send_byte(logic [7:0] b);
    DataIn      = b;
    DataInValid = 1'b1;
    wait_accept();
    DataInValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || active || post_chk) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("idle_timeout", 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    DataInValid = 1'b1;
    DataIn      = 8'($urandom);
    repeat (3) @(negedge clk);
    rst_n       = 1'b1;
    DataInValid = 1'b0;
    repeat (3) @(negedge clk);

    send_byte(8'hA5);
    wait_idle();

    DataIn      = 8'h00;
    DataInValid = 1'b1;
    wait_accept();
    DataIn = 8'hFF;
    wait_accept();
    DataInValid = 1'b0;
    wait_idle();
    if (starts.size() >= 2)
      check("b2b_start_spacing", starts[starts.size()-1] - starts[starts.size()-2], 10 * T + 1);
    else
      check("b2b_frames_seen", starts.size(), 3);

    send_byte(8'h3C);
    DataIn      = 8'hFF;
    DataInValid = 1'b1;
    repeat (5) @(negedge clk);
    DataInValid = 1'b0;
    wait_idle();

    send_byte(8'h55);
    repeat (35) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h81);
    wait_idle();

    send_byte(8'h12);
    repeat (39) @(negedge clk);
    DataIn      = 8'h77;
    DataInValid = 1'b1;
    @(negedge clk);
    DataInValid = 1'b0;
    wait_idle();
    repeat (150) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      send_byte(8'($urandom));
    end
    wait_idle();
    repeat (20) @(negedge clk);

    check("frames_vs_accepts", starts.size(), acc_cnt);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
